// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: constants, the sequencer state type and a small helper that
// are shared by the ADC sequencer top level and its watchdog.
package adc_seq_pkg;

    localparam int CFG_WAIT_DEFAULT    = 64;
    localparam int TIMEOUT_CYC_DEFAULT = 1048576;

    localparam int DF_W   = 16;  // decimation factor width
    localparam int CTRL_W = 10;  // ADC control word width
    localparam int SMP_W  = 32;  // sample width
    localparam int CNT_W  = 16;  // sample counter width

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GUARD    = 3'd1,
        ST_CFG_WAIT = 3'd2,
        ST_ACQ      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // A decimation factor of zero is meaningless to the ADC; treat it as 1.
    function automatic logic [DF_W-1:0] map_df(input logic [DF_W-1:0] df);
        return (df == {DF_W{1'b0}}) ? {{(DF_W-1){1'b0}}, 1'b1} : df;
    endfunction

endpackage

// File: rtl/adc_seq_wdog.sv
// adc_seq_wdog: loadable, clearable down-counting watchdog.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force the counter to zero (highest priority)
//   load      - reload with TIMEOUT_CYC-1
//   en        - count down by one per cycle while non-zero
//   expired   - en is high and the count has run out
module adc_seq_wdog
    import adc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int              WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] LOAD_VAL = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Next count: clear, reload, or decrement towards zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {WD_W{1'b0}};
        end else if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != {WD_W{1'b0}})) begin
            cnt_d = cnt_q - WD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {WD_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with N-1 on ACQ entry, so zero is seen in the N-th quiet cycle.
    assign expired = en && (cnt_q == {WD_W{1'b0}});

endmodule

// File: rtl/adc_seq.sv
// adc_seq: ADC run sequencer.
// Optionally loads a control word into the ADC (guard time, one-cycle
// ldctrl pulse, settle time), then acquires samples into a one-entry
// valid/ready output slot until nsamp samples, a timeout or an abort,
// drains the slot and pulses done.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   start, abort                 - one-cycle run request / cancel
//   cfg_ctrlword/df/nsamp/load   - run configuration, latched on start
//   adc_enable/df/ctrlword/ldctrl- ADC control outputs
//   adc_douta, adc_valida        - ADC sample input
//   smp_data/valid/ready/last    - downstream sample stream
//   busy, done, err_timeout, err_overrun, smp_count - status
module adc_seq
    import adc_seq_pkg::*;
#(
    parameter int CFG_WAIT    = CFG_WAIT_DEFAULT,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CTRL_W-1:0] cfg_ctrlword,
    input  logic [DF_W-1:0]   cfg_df,
    input  logic [CNT_W-1:0]  cfg_nsamp,
    input  logic              cfg_load,
    output logic              adc_enable,
    output logic [DF_W-1:0]   adc_df,
    output logic [CTRL_W-1:0] adc_ctrlword,
    output logic              adc_ldctrl,
    input  logic [SMP_W-1:0]  adc_douta,
    input  logic              adc_valida,
    output logic [SMP_W-1:0]  smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              smp_last,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic [CNT_W-1:0]  smp_count
);

    localparam int              WAIT_W    = (CFG_WAIT > 1) ? $clog2(CFG_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CFG_WAIT - 1);
    localparam logic [DF_W-1:0] DF_ONE    = DF_W'(1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CTRL_W-1:0]   ctrlword_q, ctrlword_d;
    logic [DF_W-1:0]     df_q, df_d;
    logic [CNT_W-1:0]    nsamp_q, nsamp_d;
    logic                adc_enable_q, adc_enable_d;
    logic [DF_W-1:0]     adc_df_q, adc_df_d;
    logic                adc_ldctrl_q, adc_ldctrl_d;
    logic [SMP_W-1:0]    smp_data_q, smp_data_d;
    logic                smp_valid_q, smp_valid_d;
    logic                smp_last_q, smp_last_d;
    logic [CNT_W-1:0]    smp_count_q, smp_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_overrun_q, err_overrun_d;

    logic                accept_s;
    logic [CNT_W-1:0]    count_inc_s;
    logic                wd_clr_s, wd_load_s, wd_en_s, wd_expired_s;

    assign accept_s    = smp_valid_q & smp_ready;
    assign count_inc_s = (smp_count_q == {CNT_W{1'b1}}) ? smp_count_q : (smp_count_q + CNT_W'(1));

    // Next state, configuration latch and the output sample slot.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        ctrlword_d    = ctrlword_q;
        df_d          = df_q;
        nsamp_d       = nsamp_q;
        smp_data_d    = smp_data_q;
        smp_valid_d   = smp_valid_q;
        smp_last_d    = smp_last_q;
        smp_count_d   = smp_count_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;
        adc_ldctrl_d  = 1'b0;

        // A completed handshake empties the slot unless ACQ refills it below.
        if (accept_s) begin
            smp_valid_d = 1'b0;
            smp_last_d  = 1'b0;
        end else begin
            smp_valid_d = smp_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    ctrlword_d    = cfg_ctrlword;
                    df_d          = map_df(cfg_df);
                    nsamp_d       = cfg_nsamp;
                    smp_count_d   = {CNT_W{1'b0}};
                    err_timeout_d = 1'b0;
                    err_overrun_d = 1'b0;
                    wait_cnt_d    = {WAIT_W{1'b0}};
                    state_d       = cfg_load ? ST_GUARD : ST_ACQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GUARD: begin
                // Abort wins over the final guard cycle: no ldctrl after abort.
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    adc_ldctrl_d = 1'b1;
                    wait_cnt_d   = {WAIT_W{1'b0}};
                    state_d      = ST_CFG_WAIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_CFG_WAIT: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = ST_ACQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ACQ: begin
                if (adc_valida) begin
                    if (!smp_valid_q || accept_s) begin
                        smp_data_d  = adc_douta;
                        smp_valid_d = 1'b1;
                        smp_count_d = count_inc_s;
                        if ((nsamp_q != {CNT_W{1'b0}}) && (count_inc_s == nsamp_q)) begin
                            smp_last_d = 1'b1;
                            state_d    = ST_DRAIN;
                        end else begin
                            smp_last_d = 1'b0;
                        end
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end else if (wd_expired_s) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_DRAIN;
                end else begin
                    state_d = ST_ACQ;
                end
                if (abort) begin
                    state_d = ST_DRAIN;
                end else begin
                    wait_cnt_d = {WAIT_W{1'b0}};
                end
            end
            ST_DRAIN: begin
                if (!smp_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Watchdog control and next values of the state-derived outputs.
    always_comb begin
        wd_en_s      = (state_q == ST_ACQ);
        wd_load_s    = (state_d == ST_ACQ) && ((state_q != ST_ACQ) || adc_valida);
        wd_clr_s     = (state_d != ST_ACQ);
        adc_enable_d = (state_d == ST_ACQ);
        adc_df_d     = (state_d == ST_ACQ) ? df_d : DF_ONE;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    adc_seq_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .load    (wd_load_s),
        .en      (wd_en_s),
        .expired (wd_expired_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= {WAIT_W{1'b0}};
            ctrlword_q    <= {CTRL_W{1'b0}};
            df_q          <= DF_ONE;
            nsamp_q       <= {CNT_W{1'b0}};
            adc_enable_q  <= 1'b0;
            adc_df_q      <= DF_ONE;
            adc_ldctrl_q  <= 1'b0;
            smp_data_q    <= {SMP_W{1'b0}};
            smp_valid_q   <= 1'b0;
            smp_last_q    <= 1'b0;
            smp_count_q   <= {CNT_W{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            ctrlword_q    <= ctrlword_d;
            df_q          <= df_d;
            nsamp_q       <= nsamp_d;
            adc_enable_q  <= adc_enable_d;
            adc_df_q      <= adc_df_d;
            adc_ldctrl_q  <= adc_ldctrl_d;
            smp_data_q    <= smp_data_d;
            smp_valid_q   <= smp_valid_d;
            smp_last_q    <= smp_last_d;
            smp_count_q   <= smp_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign adc_enable   = adc_enable_q;
    assign adc_df       = adc_df_q;
    assign adc_ctrlword = ctrlword_q;
    assign adc_ldctrl   = adc_ldctrl_q;
    assign smp_data     = smp_data_q;
    assign smp_valid    = smp_valid_q;
    assign smp_last     = smp_last_q;
    assign smp_count    = smp_count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_timeout_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_adc_seq.sv
// tb_adc_seq: directed bench for adc_seq with a cycle-level behavioural
// model compared against every output on every cycle after reset.
module tb_adc_seq;
    import adc_seq_pkg::*;

    localparam int CW = 64;
    localparam int TO = 100;

    localparam int P_IDLE   = 0;
    localparam int P_GUARD  = 1;
    localparam int P_SETTLE = 2;
    localparam int P_ACQ    = 3;
    localparam int P_DRAIN  = 4;
    localparam int P_DONE   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  cfg_ctrlword = 10'd0;
    logic [15:0] cfg_df = 16'd0;
    logic [15:0] cfg_nsamp = 16'd0;
    logic        cfg_load = 1'b0;
    logic [31:0] adc_douta = 32'd0;
    logic        adc_valida = 1'b0;
    logic        smp_ready = 1'b0;

    logic        adc_enable, adc_ldctrl, smp_valid, smp_last, busy, done, err_timeout, err_overrun;
    logic [15:0] adc_df, smp_count;
    logic [9:0]  adc_ctrlword;
    logic [31:0] smp_data;

    adc_seq #(.CFG_WAIT(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_ctrlword(cfg_ctrlword), .cfg_df(cfg_df), .cfg_nsamp(cfg_nsamp), .cfg_load(cfg_load),
        .adc_enable(adc_enable), .adc_df(adc_df), .adc_ctrlword(adc_ctrlword), .adc_ldctrl(adc_ldctrl),
        .adc_douta(adc_douta), .adc_valida(adc_valida),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_last(smp_last),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .smp_count(smp_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ph, m_pc, m_quiet;
    logic        m_en, m_ld, m_valid, m_last, m_busy, m_done, m_tmo, m_ovr;
    logic [31:0] m_data;
    logic [15:0] m_cnt, m_df, m_dfl, m_nsamp;
    logic [9:0]  m_ctrl;

    task automatic model_step();
        logic old_v;
        logic acc;
        int   nph;
        if (rst) begin
            m_ph = P_IDLE; m_pc = 0; m_quiet = 0;
            m_en = 1'b0; m_ld = 1'b0; m_valid = 1'b0; m_last = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_tmo = 1'b0; m_ovr = 1'b0;
            m_data = 32'd0; m_cnt = 16'd0; m_df = 16'd1; m_dfl = 16'd1;
            m_nsamp = 16'd0; m_ctrl = 10'd0;
            return;
        end
        old_v = m_valid;
        acc   = m_valid && smp_ready;
        if (acc) begin
            m_valid = 1'b0;
            m_last  = 1'b0;
        end
        m_ld = 1'b0;
        nph  = m_ph;
        if (m_ph == P_IDLE) begin
            if (start && !abort) begin
                m_ctrl  = cfg_ctrlword;
                m_dfl   = (cfg_df == 16'd0) ? 16'd1 : cfg_df;
                m_nsamp = cfg_nsamp;
                m_cnt   = 16'd0;
                m_tmo   = 1'b0;
                m_ovr   = 1'b0;
                nph     = cfg_load ? P_GUARD : P_ACQ;
            end
        end else if (m_ph == P_GUARD || m_ph == P_SETTLE) begin
            if (abort) nph = P_DRAIN;
            else if (m_pc + 1 == CW) begin
                if (m_ph == P_GUARD) begin
                    m_ld = 1'b1;
                    nph  = P_SETTLE;
                end else begin
                    nph = P_ACQ;
                end
            end
        end else if (m_ph == P_ACQ) begin
            if (adc_valida) begin
                m_quiet = 0;
                if (!old_v || acc) begin
                    m_valid = 1'b1;
                    m_data  = adc_douta;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_last = (m_nsamp != 16'd0) && (m_cnt == m_nsamp);
                    if (m_last) nph = P_DRAIN;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                m_quiet++;
                if (m_quiet == TO) begin
                    m_tmo = 1'b1;
                    nph   = P_DRAIN;
                end
            end
            if (abort) nph = P_DRAIN;
        end else if (m_ph == P_DRAIN) begin
            if (!old_v) nph = P_DONE;
        end else begin
            nph = P_IDLE;
        end
        if (nph != m_ph) begin
            m_pc = 0;
            m_quiet = 0;
        end else begin
            m_pc++;
        end
        m_ph   = nph;
        m_done = (m_ph == P_DONE);
        m_busy = (m_ph != P_IDLE);
        m_en   = (m_ph == P_ACQ);
        m_df   = (m_ph == P_ACQ) ? m_dfl : 16'd1;
    endtask

    always @(posedge clk) model_step();

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",         32'(busy),         32'(m_busy));
            chk("done",         32'(done),         32'(m_done));
            chk("adc_enable",   32'(adc_enable),   32'(m_en));
            chk("adc_ldctrl",   32'(adc_ldctrl),   32'(m_ld));
            chk("adc_df",       32'(adc_df),       32'(m_df));
            chk("adc_ctrlword", 32'(adc_ctrlword), 32'(m_ctrl));
            chk("smp_valid",    32'(smp_valid),    32'(m_valid));
            chk("smp_last",     32'(smp_last),     32'(m_last));
            chk("smp_data",     smp_data,          m_data);
            chk("smp_count",    32'(smp_count),    32'(m_cnt));
            chk("err_timeout",  32'(err_timeout),  32'(m_tmo));
            chk("err_overrun",  32'(err_overrun),  32'(m_ovr));
        end
    end

    // Delivered samples (handshake seen at the clock edge) and done pulses.
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          done_cnt = 0;

    always @(posedge clk) begin
        if (chk_en && !rst && smp_valid && smp_ready) begin
            got_d.push_back(smp_data);
            got_l.push_back(smp_last);
        end
    end

    always @(negedge clk) begin
        if (chk_en && done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic ld, input logic [9:0] cw, input logic [15:0] df,
                            input logic [15:0] ns);
        cfg_load = ld; cfg_ctrlword = cw; cfg_df = df; cfg_nsamp = ns;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        adc_valida = 1'b1; adc_douta = d;
        @(negedge clk);
        adc_valida = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    int          ld_n, ld_k, en_k, en_cnt, d0;
    logic [9:0]  ld_cw;
    logic [15:0] en_df;
    logic [31:0] exp_d [4];

    initial begin
        exp_d = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

        // Reset state
        cyc(2);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_adc_df", 32'(adc_df), 32'd1);
        chk("rst_smp_count", 32'(smp_count), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Control-word load timing
        do_start(1'b1, 10'h2A5, 16'h1234, 16'd0);
        ld_n = 0; ld_k = 0; en_k = 0; ld_cw = 10'd0; en_df = 16'd0;
        for (int k = 1; k <= 130; k++) begin
            if (adc_ldctrl === 1'b1) begin ld_n++; ld_k = k; ld_cw = adc_ctrlword; end
            if (adc_enable === 1'b1 && en_k == 0) begin en_k = k; en_df = adc_df; end
            @(negedge clk);
        end
        chk("ld_pulses", 32'(ld_n), 32'd1);
        chk("ld_cycle", 32'(ld_k), 32'd65);
        chk("ld_ctrlword", 32'(ld_cw), 32'h2A5);
        chk("acq_cycle", 32'(en_k), 32'd129);
        chk("acq_df", 32'(en_df), 32'h1234);
        d0 = done_cnt;
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        wait_idle("load_run_ends", 20);
        chk("load_run_done", 32'(done_cnt - d0), 32'd1);

        // Four samples, ready high, df 0 mapped to 1
        got_d.delete(); got_l.delete(); d0 = done_cnt;
        smp_ready = 1'b1;
        do_start(1'b0, 10'h000, 16'd0, 16'd4);
        chk("acq_enable_now", 32'(adc_enable), 32'd1);
        chk("df0_maps_to_1", 32'(adc_df), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(exp_d[i]);
            cyc(1);
        end
        wait_idle("nsamp4_ends", 20);
        chk("nsamp4_count_samples", 32'(got_d.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk("nsamp4_data", got_d[i], exp_d[i]);
            chk("nsamp4_last", 32'(got_l[i]), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("nsamp4_smp_count", 32'(smp_count), 32'd4);
        chk("nsamp4_done_once", 32'(done_cnt - d0), 32'd1);

        // Overrun with ready held low
        got_d.delete(); got_l.delete();
        smp_ready = 1'b0;
        do_start(1'b0, 10'h000, 16'd3, 16'd3);
        send(32'hCAFE_0001);
        cyc(1);
        send(32'hCAFE_0002);
        cyc(2);
        chk("ovr_held_valid", 32'(smp_valid), 32'd1);
        chk("ovr_held_data", smp_data, 32'hCAFE_0001);
        chk("ovr_count", 32'(smp_count), 32'd1);
        chk("ovr_flag", 32'(err_overrun), 32'd1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        smp_ready = 1'b1;
        wait_idle("ovr_ends", 20);
        chk("ovr_delivered", 32'(got_d.size()), 32'd1);
        chk("ovr_flag_sticky", 32'(err_overrun), 32'd1);

        // Timeout after 100 quiet ACQ cycles
        d0 = done_cnt;
        do_start(1'b0, 10'h000, 16'd2, 16'd0);
        en_cnt = 0;
        for (int k = 0; k < 300 && err_timeout !== 1'b1; k++) begin
            if (adc_enable === 1'b1) en_cnt++;
            @(negedge clk);
        end
        chk("tmo_acq_cycles", 32'(en_cnt), 32'd100);
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        wait_idle("tmo_ends", 20);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_done_once", 32'(done_cnt - d0), 32'd1);

        // Abort with a pending sample, late conversion ignored
        got_d.delete(); got_l.delete(); d0 = done_cnt;
        smp_ready = 1'b0;
        do_start(1'b0, 10'h000, 16'd1, 16'd0);
        send(32'hBEEF_0001);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        send(32'hBEEF_0002);
        cyc(3);
        smp_ready = 1'b1;
        wait_idle("abort_ends", 20);
        chk("abort_delivered", 32'(got_d.size()), 32'd1);
        if (got_d.size() > 0) chk("abort_data", got_d[0], 32'hBEEF_0001);
        chk("abort_count", 32'(smp_count), 32'd1);
        chk("abort_done_once", 32'(done_cnt - d0), 32'd1);

        // Start with abort in IDLE does nothing
        d0 = done_cnt;
        start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("start_abort_idle", 32'(busy), 32'd0);
            @(negedge clk);
        end
        chk("start_abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset in the middle of ACQ with a pending sample
        smp_ready = 1'b0;
        do_start(1'b1, 10'h155, 16'd7, 16'd0);
        cyc(2 * CW + 1);
        send(32'h5555_AAAA);
        cyc(1);
        chk("pre_rst_pending", 32'(smp_valid), 32'd1);
        rst = 1'b1; @(negedge clk);
        chk("rst_mid_enable", 32'(adc_enable), 32'd0);
        chk("rst_mid_valid", 32'(smp_valid), 32'd0);
        chk("rst_mid_data", smp_data, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ctrlword", 32'(adc_ctrlword), 32'd0);
        chk("rst_mid_df", 32'(adc_df), 32'd1);
        rst = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit reached");
    end

endmodule
